interrupt_sequencer: RTL

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer_if.sv | 51 +++++
 rtl/interrupt_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_if
// Groups the signals between the instruction decoder/core and the interrupt
// entry sequencer.
//   master : core side -- drives the INTCON/PIR1/PIE1 register values, the
//            decoder strobes (instr_boundary, retfie_done) and pc_in; observes
//            the sequencer commands.
//   slave  : sequencer side -- the mirror image.
// Signals:
//   intcon[7:0]          INTCON value (GIE,PEIE,T0IE,INTE,RBIE,T0IF,INTF,RBIF)
//   pir1[7:0]/pie1[7:0]  peripheral interrupt flags / enables
//   instr_boundary       high for the final clock (Q4) of each instruction
//   pc_in[12:0]          address of the next instruction to execute
//   retfie_done          strobe at the boundary of a RETFIE
//   force_nop            decoder flush / inject-NOP request
//   stack_push_en        one-clock hardware-stack push strobe
//   stack_push_data      return address to push
//   pc_vector_en         one-clock strobe to load vector_addr into the PC
//   vector_addr          constant interrupt vector address
//   gie_clr_en/gie_set_en one-clock strobes to clear / set INTCON.GIE
//   busy                 sequencer is not idle
// -----------------------------------------------------------------------------
interface interrupt_sequencer_if;
  logic [7:0]  intcon;
  logic [7:0]  pir1;
  logic [7:0]  pie1;
  logic        instr_boundary;
  logic [12:0] pc_in;
  logic        retfie_done;

  logic        force_nop;
  logic        stack_push_en;
  logic [12:0] stack_push_data;
  logic        pc_vector_en;
  logic [12:0] vector_addr;
  logic        gie_clr_en;
  logic        gie_set_en;
  logic        busy;

  modport master (
    output intcon, pir1, pie1, instr_boundary, pc_in, retfie_done,
    input  force_nop, stack_push_en, stack_push_data, pc_vector_en,
           vector_addr, gie_clr_en, gie_set_en, busy
  );

  modport slave (
    input  intcon, pir1, pie1, instr_boundary, pc_in, retfie_done,
    output force_nop, stack_push_en, stack_push_data, pc_vector_en,
           vector_addr, gie_clr_en, gie_set_en, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
// PIC-style interrupt entry sequencer. A registered interrupt condition arms
// the sequencer; at the next instruction boundary the return address is
// captured, the decoder is held on NOPs for one instruction cycle
// (NOP_CYCLES clocks), and then a single clock pushes the return address,
// vectors the PC and clears GIE. RETFIE re-enables GIE one clock later.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : interrupt_sequencer_if.slave (see interface header)
// Parameters:
//   VECTOR_ADDR : PC value loaded on interrupt entry
//   NOP_CYCLES  : clocks of forced NOP before vectoring (1..8, 3-bit counter)
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter logic [12:0] VECTOR_ADDR = 13'h004,
  parameter int          NOP_CYCLES  = 4
) (
  input logic                   clk,
  input logic                   rst,
  interrupt_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    NOP,
    VECTOR
  } state_e;

  localparam logic [2:0] NOP_LOAD = 3'(NOP_CYCLES - 1);

  state_e      state_q, state_d;
  logic        irq_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [12:0] push_data_q, push_data_d;
  logic        force_nop_q, force_nop_d;
  logic        vector_q, vector_d;
  logic        gie_set_q, gie_set_d;
  logic        irq_cond;

  // INTCON bit map: 7 GIE, 6 PEIE, 5 T0IE, 4 INTE, 3 RBIE, 2 T0IF, 1 INTF, 0 RBIF
  assign irq_cond = bus.intcon[7] &
                    ((bus.intcon[5] & bus.intcon[2]) |
                     (bus.intcon[4] & bus.intcon[1]) |
                     (bus.intcon[3] & bus.intcon[0]) |
                     (bus.intcon[6] & (|(bus.pir1 & bus.pie1))));

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push_data_d = push_data_q;

    unique case (state_q)
      IDLE: begin
        // A boundary seen here is deliberately ignored; entry waits for the
        // first boundary after the sequencer is armed.
        if (irq_q) state_d = ARMED;
      end
      ARMED: begin
        if (!irq_q) begin
          state_d = IDLE;
        end else if (bus.instr_boundary) begin
          state_d     = NOP;
          cnt_d       = NOP_LOAD;
          push_data_d = bus.pc_in;
        end
      end
      NOP: begin
        // Uninterruptible: only the counter decides when to leave.
        if (cnt_q == 3'd0) state_d = VECTOR;
        else               cnt_d   = cnt_q - 3'd1;
      end
      VECTOR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies, so they
    // line up exactly with the clocks spent in NOP/VECTOR.
    force_nop_d = (state_d == NOP) || (state_d == VECTOR);
    vector_d    = (state_d == VECTOR);
    gie_set_d   = bus.retfie_done && ((state_q == IDLE) || (state_q == ARMED));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      irq_q       <= 1'b0;
      cnt_q       <= 3'd0;
      push_data_q <= 13'd0;
      force_nop_q <= 1'b0;
      vector_q    <= 1'b0;
      gie_set_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_cond;
      cnt_q       <= cnt_d;
      push_data_q <= push_data_d;
      force_nop_q <= force_nop_d;
      vector_q    <= vector_d;
      gie_set_q   <= gie_set_d;
    end
  end

  // Push, vector and GIE-clear always happen together in the VECTOR clock.
  assign bus.force_nop       = force_nop_q;
  assign bus.stack_push_en   = vector_q;
  assign bus.pc_vector_en    = vector_q;
  assign bus.gie_clr_en      = vector_q;
  assign bus.stack_push_data = push_data_q;
  assign bus.gie_set_en      = gie_set_q;
  assign bus.vector_addr     = VECTOR_ADDR;
  assign bus.busy            = (state_q != IDLE);

endmodule
